fir_stream_sequencer: RTL

//  Sequences the pipelined direct-form FIR datapath between a config host and sample streams.

---
 rtl/fir_stream_sequencer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/fir_stream_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fir_stream_sequencer: clear/load/stream/drain control for a pipelined FIR, rev 1.0
// ----------------------------------------------------------------------------
module fir_stream_sequencer #(
  parameter int N   = 100,
  parameter int LAT = N + 3,
  parameter int W   = 16
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           cfg_start_i,
  input  logic           cfg_valid_i,
  output logic           cfg_ready_o,
  input  logic [W-1:0]   cfg_coeff_i,
  input  logic           flush_i,
  input  logic           s_valid_i,
  output logic           s_ready_o,
  input  logic [W-1:0]   s_data_i,
  output logic           m_valid_o,
  input  logic           m_ready_i,
  output logic [2*W-1:0] m_data_o,
  output logic           fir_clr_o,
  output logic           fir_load_coeff_o,
  output logic [W-1:0]   fir_coeff_o,
  output logic           fir_start_o,
  output logic [W-1:0]   fir_x_o,
  input  logic [2*W-1:0] fir_y_i,
  output logic           busy_o
);

  localparam int CW = $clog2(N + 1);
  localparam int LW = $clog2(LAT + 1);
  localparam logic [CW-1:0] C_CFG_LAST   = CW'(N - 1);
  localparam logic [LW-1:0] C_FILL_MAX   = LW'(LAT);
  localparam logic [LW-1:0] C_FILL_EMIT  = LW'(LAT - 1);
  localparam logic [LW-1:0] C_DRAIN_LAST = LW'(LAT - 2);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_LOAD  = 3'd2,
    S_RUN   = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cfg_cnt_q, cfg_cnt_d;
  logic [LW-1:0]   fill_q, fill_d;
  logic [LW-1:0]   drain_cnt_q, drain_cnt_d;
  logic            m_valid_q, m_valid_d;
  logic            fir_clr_q, fir_clr_d;
  logic            adv;
  logic            out_free;

  // An advance is only allowed when no unaccepted result sits on m_data.
  assign out_free = !(m_valid_q && !m_ready_i);

  always_comb begin
    state_d          = state_q;
    cfg_cnt_d        = cfg_cnt_q;
    fill_d           = fill_q;
    drain_cnt_d      = drain_cnt_q;
    fir_clr_d        = 1'b0;
    adv              = 1'b0;
    cfg_ready_o      = 1'b0;
    s_ready_o        = 1'b0;
    fir_load_coeff_o = 1'b0;
    fir_coeff_o      = '0;
    fir_start_o      = 1'b0;
    fir_x_o          = '0;

    case (state_q)
      S_IDLE: begin
        if (cfg_start_i) begin
          state_d   = S_CLR;
          fir_clr_d = 1'b1;
        end
      end
      S_CLR: begin
        cfg_cnt_d = '0;
        state_d   = S_LOAD;
      end
      S_LOAD: begin
        cfg_ready_o = 1'b1;
        if (cfg_valid_i) begin
          fir_load_coeff_o = 1'b1;
          fir_coeff_o      = cfg_coeff_i;
          if (cfg_cnt_q == C_CFG_LAST) begin
            cfg_cnt_d = '0;
            fill_d    = '0;
            state_d   = S_RUN;
          end else begin
            cfg_cnt_d = cfg_cnt_q + 1'b1;
          end
        end
      end
      S_RUN: begin
        s_ready_o = out_free;
        if (s_valid_i && out_free) begin
          adv         = 1'b1;
          fir_start_o = 1'b1;
          fir_x_o     = s_data_i;
        end
        if (flush_i) begin
          drain_cnt_d = '0;
          state_d     = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (out_free) begin
          adv         = 1'b1;
          fir_start_o = 1'b1;
          if (drain_cnt_q == C_DRAIN_LAST) begin
            state_d = S_IDLE;
          end else begin
            drain_cnt_d = drain_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (adv && (fill_q != C_FILL_MAX)) begin
      fill_d = fill_q + 1'b1;
    end

    // A new result on the same edge as a handshake keeps m_valid high.
    if (adv && (fill_q >= C_FILL_EMIT)) begin
      m_valid_d = 1'b1;
    end else if (m_ready_i) begin
      m_valid_d = 1'b0;
    end else begin
      m_valid_d = m_valid_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      cfg_cnt_q   <= '0;
      fill_q      <= '0;
      drain_cnt_q <= '0;
      m_valid_q   <= 1'b0;
      fir_clr_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_cnt_q   <= cfg_cnt_d;
      fill_q      <= fill_d;
      drain_cnt_q <= drain_cnt_d;
      m_valid_q   <= m_valid_d;
      fir_clr_q   <= fir_clr_d;
    end
  end

  assign m_valid_o = m_valid_q;
  assign m_data_o  = m_valid_q ? fir_y_i : '0;
  assign fir_clr_o = fir_clr_q;
  assign busy_o    = (state_q != S_IDLE);

endmodule
`default_nettype wire
